// File: rtl/his_builder_pingpong_pkg.sv
// his_builder_pingpong_pkg: default parameters and width helper for the ping-pong histogram builder
package his_builder_pingpong_pkg;
    localparam int DEF_ADDR_W    = 6;
    localparam int DEF_BIN_NUM   = 64;
    localparam int DEF_PIXEL_NUM = 4;
    localparam int DEF_DATA_NUM  = 2;
    localparam int DEF_ACQ_NUM   = 16;
    localparam int DEF_CNT_W     = 8;
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/his_bank.sv
// his_bank: one histogram bank with valid-masked counts, saturating increment and single-cycle clear
module his_bank #(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             clr,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [IDX_W-1:0] raddr,
    output logic [CNT_W-1:0] wnext,
    output logic [CNT_W-1:0] rdata
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [CNT_W-1:0] cnt [DEPTH];
    logic [DEPTH-1:0] vld;
    always_comb begin
        wnext = !vld[waddr] ? CNT_W'(1) : (cnt[waddr] == CNT_MAX) ? CNT_MAX : cnt[waddr] + 1'b1;
        rdata = vld[raddr] ? cnt[raddr] : '0;
    end
    // count storage is never cleared; the valid vector alone retires stale entries
    always_ff @(posedge clk)
        if (we) cnt[waddr] <= wnext;
    always_ff @(posedge clk or negedge res)
        if (!res) vld <= '0;
        else if (clr) vld <= '0;
        else if (we) vld[waddr] <= 1'b1;
endmodule

// File: rtl/his_builder_pingpong.sv
// his_builder_pingpong: ping-pong dToF histogram builder; HIS_PEAK_TRACK_EN adds per-frame peak outputs
module his_builder_pingpong
    import his_builder_pingpong_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BIN_NUM   = DEF_BIN_NUM,
    parameter int PIXEL_NUM = DEF_PIXEL_NUM,
    parameter int DATA_NUM  = DEF_DATA_NUM,
    parameter int ACQ_NUM   = DEF_ACQ_NUM,
    parameter int CNT_W     = DEF_CNT_W,
    localparam int IDX_W    = $clog2(PIXEL_NUM * BIN_NUM)
) (
    input  logic              clk,
    input  logic              res,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    output logic [CNT_W-1:0]  bin_counts,
    output logic              his_num,
    output logic              frame_done,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_valid,
    output logic              oor_err
`ifdef HIS_PEAK_TRACK_EN
    ,
    output logic [CNT_W-1:0]  peak_cnt,
    output logic [IDX_W-1:0]  peak_idx
`endif
);
    localparam int DW    = cw(DATA_NUM);
    localparam int PW    = cw(PIXEL_NUM);
    localparam int AW    = cw(ACQ_NUM);
    localparam int DEPTH = PIXEL_NUM * BIN_NUM;
    logic [DW-1:0]    input_count;
    logic [PW-1:0]    pixel_count;
    logic [AW-1:0]    acq_count;
    logic             last_in, last_px, last_acq, frame_end, in_rng, rd_rng, we;
    logic [IDX_W-1:0] widx;
    logic [CNT_W-1:0] wnext [2];
    logic [CNT_W-1:0] rdata [2];
    logic [CNT_W-1:0] wsel;
    always_comb begin
        last_in   = input_count == DW'(DATA_NUM - 1);
        last_px   = pixel_count == PW'(PIXEL_NUM - 1);
        last_acq  = acq_count == AW'(ACQ_NUM - 1);
        frame_end = wr_en && last_in && last_px && last_acq;
        in_rng    = int'(addr) < BIN_NUM;
        rd_rng    = int'(rd_addr) < DEPTH;
        we        = wr_en && in_rng;
        widx      = IDX_W'(int'(pixel_count) * BIN_NUM + int'(addr));
        wsel      = wnext[his_num];
    end
    // the bank being retired to readable keeps its data; only the other one is cleared at the swap
    for (genvar b = 0; b < 2; b++) begin : g_bank
        his_bank #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_bank (
            .clk   (clk),
            .res   (res),
            .clr   (frame_end && his_num != 1'(b)),
            .we    (we && his_num == 1'(b)),
            .waddr (widx),
            .raddr (rd_addr),
            .wnext (wnext[b]),
            .rdata (rdata[b])
        );
    end
    always_ff @(posedge clk or negedge res)
        if (!res) begin
            input_count <= '0;
            pixel_count <= '0;
            acq_count   <= '0;
            his_num     <= 1'b0;
            bin_counts  <= '0;
            frame_done  <= 1'b0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            oor_err     <= 1'b0;
        end else begin
            frame_done <= frame_end;
            rd_valid   <= rd_en;
            if (rd_en) rd_data <= rd_rng ? rdata[~his_num] : '0;
            if (we) bin_counts <= wsel;
            if (wr_en && !in_rng) oor_err <= 1'b1;
            if (wr_en) begin
                input_count <= last_in ? '0 : input_count + 1'b1;
                if (last_in) pixel_count <= last_px ? '0 : pixel_count + 1'b1;
                if (last_in && last_px) acq_count <= last_acq ? '0 : acq_count + 1'b1;
            end
            if (frame_end) his_num <= ~his_num;
        end
`ifdef HIS_PEAK_TRACK_EN
    logic [CNT_W-1:0] run_cnt, nxt_cnt;
    logic [IDX_W-1:0] run_idx, nxt_idx;
    always_comb begin
        nxt_cnt = (we && wsel > run_cnt) ? wsel : run_cnt;
        nxt_idx = (we && wsel > run_cnt) ? widx : run_idx;
    end
    always_ff @(posedge clk or negedge res)
        if (!res) begin
            run_cnt  <= '0;
            run_idx  <= '0;
            peak_cnt <= '0;
            peak_idx <= '0;
        end else if (frame_end) begin
            peak_cnt <= nxt_cnt;
            peak_idx <= nxt_idx;
            run_cnt  <= '0;
            run_idx  <= '0;
        end else begin
            run_cnt <= nxt_cnt;
            run_idx <= nxt_idx;
        end
`endif
endmodule

// File: tb/tb_his_builder_pingpong.sv
// tb_his_builder_pingpong: scoreboard bench for the ping-pong histogram builder
module tb_his_builder_pingpong;
    localparam int N = 256;
    logic       clk = 1'b0, res = 1'b0;
    logic       wr_en = 1'b0, rd_en = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] rd_addr = '0;
    logic [7:0] bin_counts, rd_data;
    logic       his_num, frame_done, rd_valid, oor_err;
    logic       wr_en4 = 1'b0, rd_en4 = 1'b0;
    logic [5:0] addr4 = '0, rd_addr4 = '0;
    logic [3:0] bin_counts4, rd_data4;
    logic       his_num4, frame_done4, rd_valid4, oor_err4;
    int total = 0, bad = 0;
    int exp_mem[N];
    int prev_mem[N];
    int rq[$];
    int bq[$];
    int mdl_bc = 0;
    bit mdl_oor = 0, mdl_his = 0;

    his_builder_pingpong #(.ADDR_W(7)) dut (
        .clk(clk), .res(res), .wr_en(wr_en), .addr(addr), .bin_counts(bin_counts),
        .his_num(his_num), .frame_done(frame_done), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .oor_err(oor_err)
    );
    his_builder_pingpong #(.CNT_W(4), .PIXEL_NUM(1), .DATA_NUM(4), .ACQ_NUM(8)) dut4 (
        .clk(clk), .res(res), .wr_en(wr_en4), .addr(addr4), .bin_counts(bin_counts4),
        .his_num(his_num4), .frame_done(frame_done4), .rd_en(rd_en4), .rd_addr(rd_addr4),
        .rd_data(rd_data4), .rd_valid(rd_valid4), .oor_err(oor_err4)
    );

    always #5 clk = ~clk;

    task automatic read_bank();
        int e;
        for (int i = 0; i < N; i++) begin
            rd_en = 1'b1;
            rd_addr = 8'(i);
            rq.push_back(exp_mem[i]);
            @(posedge clk); #1;
            e = rq.pop_front();
            total += 2;
            if (rd_valid !== 1'b1 || rd_data !== 8'(e)) begin
                bad++;
                $display("FAIL read[%0d]: got valid=%b data=%0d, want valid=1 data=%0d", i, rd_valid, rd_data, e);
            end
            if (frame_done !== 1'b0) begin
                bad++;
                $display("FAIL idle_frame_done[%0d]: got %b want 0", i, frame_done);
            end
        end
        rd_en = 1'b0;
        @(posedge clk); #1;
        total++;
        if (rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL rd_valid_drop: got %b want 0", rd_valid);
        end
    endtask

    task automatic run_frame(input int a[128], input bit swap_rd, input int swap_idx);
        int px, k, e;
        prev_mem = exp_mem;
        foreach (exp_mem[i]) exp_mem[i] = 0;
        for (int s = 0; s < 128; s++) begin
            px = (s / 2) % 4;
            wr_en = 1'b1;
            addr = 7'(a[s]);
            if (a[s] < 64) begin
                k = px * 64 + a[s];
                exp_mem[k] = exp_mem[k] < 255 ? exp_mem[k] + 1 : 255;
                mdl_bc = exp_mem[k];
            end else mdl_oor = 1'b1;
            if (swap_rd && s == 127) begin
                rd_en = 1'b1;
                rd_addr = 8'(swap_idx);
                rq.push_back(prev_mem[swap_idx]);
            end
            @(posedge clk); #1;
            total += 3;
            if (bin_counts !== 8'(mdl_bc)) begin
                bad++;
                $display("FAIL bin_counts[s=%0d]: got %0d want %0d", s, bin_counts, mdl_bc);
            end
            if (oor_err !== mdl_oor) begin
                bad++;
                $display("FAIL oor_err[s=%0d]: got %b want %b", s, oor_err, mdl_oor);
            end
            if (frame_done !== (s == 127)) begin
                bad++;
                $display("FAIL frame_done[s=%0d]: got %b want %b", s, frame_done, s == 127);
            end
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        mdl_his = ~mdl_his;
        total++;
        if (his_num !== mdl_his) begin
            bad++;
            $display("FAIL his_num_swap: got %b want %b", his_num, mdl_his);
        end
        if (swap_rd) begin
            e = rq.pop_front();
            total++;
            if (rd_valid !== 1'b1 || rd_data !== 8'(e)) begin
                bad++;
                $display("FAIL swap_read: got valid=%b data=%0d, want valid=1 data=%0d", rd_valid, rd_data, e);
            end
        end
    endtask

    task automatic test_reset();
        res = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total += 6;
        if (his_num !== 1'b0) begin bad++; $display("FAIL rst_his_num: got %b want 0", his_num); end
        if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
        if (bin_counts !== 8'd0) begin bad++; $display("FAIL rst_bin_counts: got %0d want 0", bin_counts); end
        if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_valid: got %b want 0", rd_valid); end
        if (oor_err !== 1'b0) begin bad++; $display("FAIL rst_oor_err: got %b want 0", oor_err); end
        if (bin_counts4 !== 4'd0) begin bad++; $display("FAIL rst_bin_counts4: got %0d want 0", bin_counts4); end
        res = 1'b1;
        @(posedge clk); #1;
        foreach (exp_mem[i]) exp_mem[i] = 0;
        read_bank();
    endtask

    task automatic test_single_bin();
        int a[128];
        foreach (a[i]) a[i] = 5;
        run_frame(a, 1'b0, 0);
        read_bank();
    endtask

    task automatic test_back_to_back();
        int a[128];
        foreach (a[i]) a[i] = 3;
        run_frame(a, 1'b0, 0);
        foreach (a[i]) a[i] = 7;
        run_frame(a, 1'b1, 64 + 3);
        read_bank();
    endtask

    task automatic test_oor();
        int a[128];
        foreach (a[i]) a[i] = (i % 5) + 20;
        a[10] = 70;
        a[90] = 127;
        run_frame(a, 1'b0, 0);
        read_bank();
    endtask

    task automatic test_midframe_reset();
        int a[128];
        for (int s = 0; s < 50; s++) begin
            wr_en = 1'b1;
            addr = 7'd9;
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        res = 1'b0;
        #1;
        total += 3;
        if (his_num !== 1'b0) begin bad++; $display("FAIL mid_rst_his_num: got %b want 0", his_num); end
        if (oor_err !== 1'b0) begin bad++; $display("FAIL mid_rst_oor_err: got %b want 0", oor_err); end
        if (bin_counts !== 8'd0) begin bad++; $display("FAIL mid_rst_bin_counts: got %0d want 0", bin_counts); end
        mdl_bc = 0;
        mdl_oor = 1'b0;
        mdl_his = 1'b0;
        @(posedge clk); #1;
        res = 1'b1;
        @(posedge clk); #1;
        foreach (a[i]) a[i] = 9;
        run_frame(a, 1'b0, 0);
        read_bank();
    endtask

    task automatic test_saturate();
        int e;
        int ra[2] = '{9, 0};
        int ev[2] = '{15, 12};
        for (int s = 0; s < 32; s++) begin
            wr_en4 = 1'b1;
            addr4 = s < 20 ? 6'd9 : 6'd0;
            bq.push_back(s < 20 ? (s + 1 > 15 ? 15 : s + 1) : s - 19);
            @(posedge clk); #1;
            e = bq.pop_front();
            total += 2;
            if (bin_counts4 !== 4'(e)) begin
                bad++;
                $display("FAIL sat_bin_counts[s=%0d]: got %0d want %0d", s, bin_counts4, e);
            end
            if (frame_done4 !== (s == 31)) begin
                bad++;
                $display("FAIL sat_frame_done[s=%0d]: got %b want %b", s, frame_done4, s == 31);
            end
        end
        wr_en4 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rd_en4 = 1'b1;
            rd_addr4 = 6'(ra[i]);
            rq.push_back(ev[i]);
            @(posedge clk); #1;
            e = rq.pop_front();
            total++;
            if (rd_valid4 !== 1'b1 || rd_data4 !== 4'(e)) begin
                bad++;
                $display("FAIL sat_read[%0d]: got valid=%b data=%0d, want valid=1 data=%0d", ra[i], rd_valid4, rd_data4, e);
            end
        end
        rd_en4 = 1'b0;
        total++;
        if (his_num4 !== 1'b1) begin bad++; $display("FAIL sat_his_num: got %b want 1", his_num4); end
    endtask

    initial begin
        test_reset();
        test_single_bin();
        test_back_to_back();
        test_oor();
        test_midframe_reset();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
